// File: rtl/ltssm_pkg.sv
// Shared LTSSM receive-side definitions: substate codes,
// match-run lengths and port-direction encodings (also used by os_checker).
package ltssm_pkg;

   typedef enum logic [3:0] {
      S_DET_QUIET     = 4'd0,
      S_DET_ACTIVE    = 4'd1,
      S_POLL_ACTIVE   = 4'd2,
      S_POLL_CFG      = 4'd3,
      S_CFG_LW_START  = 4'd4,
      S_CFG_LW_ACCEPT = 4'd5,
      S_CFG_LN_WAIT   = 4'd6,
      S_CFG_LN_ACCEPT = 4'd7,
      S_CFG_COMPLETE  = 4'd8,
      S_CFG_IDLE      = 4'd9
   } substate_t;

   localparam logic [3:0] REQ_N_LONG  = 4'd8;
   localparam logic [3:0] REQ_N_SHORT = 4'd2;

   localparam logic DEV_DOWNSTREAM = 1'b0;
   localparam logic DEV_UPSTREAM   = 1'b1;

   // Consecutive ordered sets needed to leave a substate.
   function automatic logic [3:0] req_n(input logic [3:0] s);
      logic [3:0] n;
      n = REQ_N_LONG;
      if (s >= 4'd4 && s <= 4'd7) n = REQ_N_SHORT;
      return n;
   endfunction

endpackage

// File: rtl/ltssm_timer.sv
// Substate dwell timer: clears on clr, otherwise increments.
// Ports: clk, reset (async active-low), clr, limit -> hit (timer == limit).
module ltssm_timer #(
   parameter int unsigned W = 24
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic [W-1:0] limit,
   output logic         hit
);

   logic [W-1:0] timer;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         timer <= '0;
      end else if (clr) begin
         timer <= '0;
      end else begin
         timer <= timer + W'(1);
      end
   end

   assign hit = (timer == limit);

endmodule

// File: rtl/rx_ltssm_sequencer.sv
// Receive-side LTSSM substate sequencer (detect/polling/configuration).
// Ports: clk, reset (async active-low), checker countup/resetcounter/
// rateid_in/upcfg_in, elec_idle_exit, rx_detected -> substate, chk_reset,
// link_up, timeout, link_rate, link_upcfg.
module rx_ltssm_sequencer
   import ltssm_pkg::*;
#(
   parameter logic        DEVICETYPE = DEV_DOWNSTREAM,
   parameter logic [23:0] T_QUIET    = 24'd1200,
   parameter logic [23:0] T_POLL     = 24'd2400,
   parameter logic [23:0] T_CFG      = 24'd200
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       countup,
   input  logic       resetcounter,
   input  logic [7:0] rateid_in,
   input  logic       upcfg_in,
   input  logic       elec_idle_exit,
   input  logic       rx_detected,
   output logic [3:0] substate,
   output logic       chk_reset,
   output logic       link_up,
   output logic       timeout,
   output logic [7:0] link_rate,
   output logic       link_upcfg
);

   substate_t   state;
   substate_t   nxt;
   substate_t   adv;
   logic [3:0]  cnt;
   logic        done;
   logic        t_hit;
   logic        chg;
   logic        first;
   logic        to_exit;
   logic [23:0] limit;

   // chk_reset is low exactly in the first cycle of a substate.
   assign first    = ~chk_reset;
   assign done     = (cnt >= req_n(state) - 4'd1);
   assign chg      = (nxt != state);
   assign substate = state;

   always_comb begin
      limit = '1;
      case (state)
         S_DET_QUIET:   limit = T_QUIET - 24'd1;
         S_POLL_ACTIVE: limit = T_POLL - 24'd1;
         S_POLL_CFG,
         S_CFG_LW_START,
         S_CFG_LW_ACCEPT,
         S_CFG_LN_WAIT,
         S_CFG_LN_ACCEPT,
         S_CFG_COMPLETE: limit = T_CFG - 24'd1;
         default:       limit = '1;
      endcase
   end

   always_comb begin
      adv = S_CFG_IDLE;
      case (state)
         S_POLL_ACTIVE:   adv = S_POLL_CFG;
         S_POLL_CFG:      adv = S_CFG_LW_START;
         S_CFG_LW_START:  adv = (DEVICETYPE == DEV_UPSTREAM) ?
                                S_CFG_LW_ACCEPT : S_CFG_LN_WAIT;
         S_CFG_LW_ACCEPT: adv = S_CFG_LN_WAIT;
         S_CFG_LN_WAIT:   adv = S_CFG_LN_ACCEPT;
         S_CFG_LN_ACCEPT: adv = S_CFG_COMPLETE;
         default:         adv = S_CFG_IDLE;
      endcase
   end

   // A completed run wins over a timer expiry in the same cycle.
   always_comb begin
      nxt     = S_DET_QUIET;
      to_exit = 1'b0;
      case (state)
         S_DET_QUIET: begin
            nxt = (elec_idle_exit || t_hit) ? S_DET_ACTIVE : S_DET_QUIET;
         end
         S_DET_ACTIVE: begin
            nxt = rx_detected ? S_POLL_ACTIVE : S_DET_QUIET;
         end
         S_POLL_ACTIVE,
         S_POLL_CFG,
         S_CFG_LW_START,
         S_CFG_LW_ACCEPT,
         S_CFG_LN_WAIT,
         S_CFG_LN_ACCEPT,
         S_CFG_COMPLETE: begin
            if (done) begin
               nxt = adv;
            end else if (t_hit) begin
               nxt     = S_DET_QUIET;
               to_exit = 1'b1;
            end else begin
               nxt = state;
            end
         end
         S_CFG_IDLE: nxt = S_CFG_IDLE;
         default:    nxt = S_DET_QUIET;
      endcase
   end

   ltssm_timer #(
      .W(24)
   ) u_timer (
      .clk   (clk),
      .reset (reset),
      .clr   (chg),
      .limit (limit),
      .hit   (t_hit)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= S_DET_QUIET;
         cnt        <= 4'd0;
         chk_reset  <= 1'b0;
         link_up    <= 1'b0;
         timeout    <= 1'b0;
         link_rate  <= 8'h00;
         link_upcfg <= 1'b0;
      end else begin
         state     <= nxt;
         chk_reset <= ~chg;
         link_up   <= (nxt == S_CFG_IDLE);
         timeout   <= to_exit;
         // Checker output is stale while it sits in reset.
         if (chg || (!first && !resetcounter)) begin
            cnt <= 4'd0;
         end else if (!first && countup && cnt != 4'hF) begin
            cnt <= cnt + 4'd1;
         end
         if (chg && nxt == S_CFG_IDLE) begin
            link_rate  <= rateid_in;
            link_upcfg <= upcfg_in;
         end
      end
   end

endmodule

// File: tb/tb_rx_ltssm_sequencer.sv
// Directed bench for rx_ltssm_sequencer: downstream and upstream
// instances share stimulus, with separate resets.
module tb_rx_ltssm_sequencer;

   logic       clk = 1'b0;
   logic       rst0;
   logic       rst1;
   logic       countup;
   logic       resetcounter;
   logic [7:0] rateid_in;
   logic       upcfg_in;
   logic       elec_idle_exit;
   logic       rx_detected;

   logic [3:0] s0, s1;
   logic       cr0, cr1, lu0, lu1, to0, to1, lc0, lc1;
   logic [7:0] lr0, lr1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rx_ltssm_sequencer #(.DEVICETYPE(1'b0)) dut0 (
      .clk(clk), .reset(rst0),
      .countup(countup), .resetcounter(resetcounter),
      .rateid_in(rateid_in), .upcfg_in(upcfg_in),
      .elec_idle_exit(elec_idle_exit), .rx_detected(rx_detected),
      .substate(s0), .chk_reset(cr0), .link_up(lu0),
      .timeout(to0), .link_rate(lr0), .link_upcfg(lc0)
   );

   rx_ltssm_sequencer #(.DEVICETYPE(1'b1)) dut1 (
      .clk(clk), .reset(rst1),
      .countup(countup), .resetcounter(resetcounter),
      .rateid_in(rateid_in), .upcfg_in(upcfg_in),
      .elec_idle_exit(elec_idle_exit), .rx_detected(rx_detected),
      .substate(s1), .chk_reset(cr1), .link_up(lu1),
      .timeout(to1), .link_rate(lr1), .link_upcfg(lc1)
   );

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset;
      rst0 = 1'b0; rst1 = 1'b0;
      countup = 1'b0; resetcounter = 1'b0;
      rateid_in = 8'h00; upcfg_in = 1'b0;
      elec_idle_exit = 1'b0; rx_detected = 1'b0;
      #3;
      checks++;
      if ({s0, cr0, lu0, to0, lr0, lc0} !== 16'h0) begin
         errors++;
         $display("FAIL reset_dut0 got=%h exp=0000",
                  {s0, cr0, lu0, to0, lr0, lc0});
      end
      checks++;
      if ({s1, cr1, lu1, to1, lr1, lc1} !== 16'h0) begin
         errors++;
         $display("FAIL reset_dut1 got=%h exp=0000",
                  {s1, cr1, lu1, to1, lr1, lc1});
      end
      step(1);
      rst0 = 1'b1; rst1 = 1'b1;
      #1;
      checks++;
      if (cr0 !== 1'b0) begin
         errors++;
         $display("FAIL chk_reset_before_edge got=%b exp=0", cr0);
      end
      step(1);
      checks++;
      if (cr0 !== 1'b1 || s0 !== 4'd0) begin
         errors++;
         $display("FAIL chk_reset_after_edge got=%b/%0d exp=1/0", cr0, s0);
      end
   endtask

   task automatic test_detect;
      step(3);
      elec_idle_exit = 1'b1; rx_detected = 1'b1;
      step(1);
      checks++;
      if (s0 !== 4'd1 || cr0 !== 1'b0 || s1 !== 4'd1) begin
         errors++;
         $display("FAIL det_active got=%0d/%b/%0d exp=1/0/1", s0, cr0, s1);
      end
      elec_idle_exit = 1'b0;
      step(1);
      checks++;
      if (s0 !== 4'd2 || cr0 !== 1'b0) begin
         errors++;
         $display("FAIL poll_entry got=%0d/%b exp=2/0", s0, cr0);
      end
      step(1);
      checks++;
      if (s0 !== 4'd2 || cr0 !== 1'b1) begin
         errors++;
         $display("FAIL poll_settle got=%0d/%b exp=2/1", s0, cr0);
      end
   endtask

   task automatic test_poll_count;
      resetcounter = 1'b1; countup = 1'b1;
      step(5);
      countup = 1'b0; resetcounter = 1'b0;
      step(1);
      resetcounter = 1'b1; countup = 1'b1;
      step(6);
      checks++;
      if (s0 !== 4'd2) begin
         errors++;
         $display("FAIL poll_run_broken got=%0d exp=2", s0);
      end
      step(1);
      checks++;
      if (s0 !== 4'd2) begin
         errors++;
         $display("FAIL poll_seventh got=%0d exp=2", s0);
      end
      countup = 1'b0;
      step(1);
      checks++;
      if (s0 !== 4'd3 || cr0 !== 1'b0) begin
         errors++;
         $display("FAIL poll_advance got=%0d/%b exp=3/0", s0, cr0);
      end
   endtask

   task automatic test_ignore_first;
      countup = 1'b1; resetcounter = 1'b1;
      step(8);
      checks++;
      if (s0 !== 4'd3) begin
         errors++;
         $display("FAIL first_cycle_ignored got=%0d exp=3", s0);
      end
      step(1);
      countup = 1'b0;
      checks++;
      if (s0 !== 4'd4 || s1 !== 4'd4) begin
         errors++;
         $display("FAIL lw_start got=%0d/%0d exp=4/4", s0, s1);
      end
   endtask

   task automatic test_devtype;
      step(1);
      countup = 1'b1;
      step(1);
      countup = 1'b0;
      checks++;
      if (s0 !== 4'd4 || s1 !== 4'd4) begin
         errors++;
         $display("FAIL lw_hold got=%0d/%0d exp=4/4", s0, s1);
      end
      step(1);
      checks++;
      if (s0 !== 4'd6 || s1 !== 4'd5) begin
         errors++;
         $display("FAIL devtype_split got=%0d/%0d exp=6/5", s0, s1);
      end
      step(1);
      countup = 1'b1;
      step(1);
      countup = 1'b0;
      step(1);
      checks++;
      if (s0 !== 4'd7 || s1 !== 4'd6) begin
         errors++;
         $display("FAIL ln_step got=%0d/%0d exp=7/6", s0, s1);
      end
      step(1);
      countup = 1'b1;
      step(1);
      countup = 1'b0;
      step(1);
      checks++;
      if (s0 !== 4'd8 || s1 !== 4'd7) begin
         errors++;
         $display("FAIL ln_accept got=%0d/%0d exp=8/7", s0, s1);
      end
   endtask

   task automatic test_reset_mid;
      #2;
      rst1 = 1'b0;
      #1;
      checks++;
      if ({s1, cr1, lu1, to1, lr1, lc1} !== 16'h0) begin
         errors++;
         $display("FAIL async_reset_s7 got=%h exp=0000",
                  {s1, cr1, lu1, to1, lr1, lc1});
      end
      checks++;
      if (s0 !== 4'd8) begin
         errors++;
         $display("FAIL other_unaffected got=%0d exp=8", s0);
      end
   endtask

   task automatic test_complete;
      step(1);
      rateid_in = 8'h1F; upcfg_in = 1'b1;
      countup = 1'b1;
      step(7);
      countup = 1'b0;
      checks++;
      if (s0 !== 4'd8 || lu0 !== 1'b0) begin
         errors++;
         $display("FAIL cmpl_hold got=%0d/%b exp=8/0", s0, lu0);
      end
      step(1);
      checks++;
      if (s0 !== 4'd9 || lu0 !== 1'b1 || lr0 !== 8'h1F || lc0 !== 1'b1) begin
         errors++;
         $display("FAIL idle_entry got=%0d/%b/%h/%b exp=9/1/1f/1",
                  s0, lu0, lr0, lc0);
      end
      rateid_in = 8'h05; upcfg_in = 1'b0;
      countup = 1'b1;
      step(30);
      countup = 1'b0; resetcounter = 1'b0;
      step(250);
      checks++;
      if (s0 !== 4'd9 || lu0 !== 1'b1 || lr0 !== 8'h1F ||
          lc0 !== 1'b1 || to0 !== 1'b0) begin
         errors++;
         $display("FAIL idle_hold got=%0d/%b/%h/%b/%b exp=9/1/1f/1/0",
                  s0, lu0, lr0, lc0, to0);
      end
   endtask

   task automatic test_timeout;
      rst0 = 1'b0; rst1 = 1'b0;
      step(1);
      rst0 = 1'b1; rst1 = 1'b1;
      resetcounter = 1'b1; countup = 1'b0;
      elec_idle_exit = 1'b1; rx_detected = 1'b0;
      step(1);
      checks++;
      if (s0 !== 4'd1) begin
         errors++;
         $display("FAIL det_active2 got=%0d exp=1", s0);
      end
      step(1);
      checks++;
      if (s0 !== 4'd0) begin
         errors++;
         $display("FAIL no_receiver got=%0d exp=0", s0);
      end
      rx_detected = 1'b1;
      step(2);
      elec_idle_exit = 1'b0;
      checks++;
      if (s0 !== 4'd2) begin
         errors++;
         $display("FAIL poll_reentry got=%0d exp=2", s0);
      end
      step(2399);
      checks++;
      if (s0 !== 4'd2 || to0 !== 1'b0) begin
         errors++;
         $display("FAIL poll_pre_timeout got=%0d/%b exp=2/0", s0, to0);
      end
      step(1);
      checks++;
      if (s0 !== 4'd0 || to0 !== 1'b1 || cr0 !== 1'b0) begin
         errors++;
         $display("FAIL poll_timeout got=%0d/%b/%b exp=0/1/0", s0, to0, cr0);
      end
      step(1);
      checks++;
      if (to0 !== 1'b0) begin
         errors++;
         $display("FAIL timeout_pulse got=%b exp=0", to0);
      end
   endtask

   task automatic test_done_vs_timeout;
      elec_idle_exit = 1'b1;
      step(2);
      elec_idle_exit = 1'b0;
      checks++;
      if (s0 !== 4'd2) begin
         errors++;
         $display("FAIL poll_third_entry got=%0d exp=2", s0);
      end
      step(2392);
      countup = 1'b1;
      step(7);
      countup = 1'b0;
      checks++;
      if (s0 !== 4'd2) begin
         errors++;
         $display("FAIL tie_hold got=%0d exp=2", s0);
      end
      step(1);
      checks++;
      if (s0 !== 4'd3 || to0 !== 1'b0) begin
         errors++;
         $display("FAIL done_priority got=%0d/%b exp=3/0", s0, to0);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_detect();
      test_poll_count();
      test_ignore_first();
      test_devtype();
      test_reset_mid();
      test_complete();
      test_timeout();
      test_done_vs_timeout();
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
